// File: rtl/cnn_pixel_feeder.sv
// Upstream pixel source for the CNN chip: holds one frame, resets the chip,
// streams the frame one pixel per cycle and scores the chip's decision.
module cnn_pixel_feeder #(
  parameter int NPIX       = 784,
  parameter int RST_CYCLES = 1,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [9:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             start,
  input  logic [3:0]       label,
  output logic             busy,
  output logic             cnn_rst_n,
  output logic [7:0]       data_out,
  input  logic             valid_in,
  input  logic [3:0]       decision_in,
  output logic             result_valid,
  output logic [3:0]       result_decision,
  output logic             result_hit,
  output logic             result_timeout,
  output logic [CNT_W-1:0] img_count,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRST   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int PW = $clog2(NPIX + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [9:0]       NPIX_A   = 10'(NPIX);
  localparam logic [PW-1:0]    PIX_END  = PW'(NPIX);
  localparam logic [3:0]       RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [2:0]    state;
  logic [3:0]    rst_cnt;
  logic [PW-1:0] pix;
  logic [PW-1:0] rd_addr;
  logic [TW-1:0] wcnt;
  logic [3:0]    lbl;
  logic          is_hit;

  logic [7:0] mem [NPIX];

  always_ff @(posedge clk) begin
    if (state == S_IDLE && wr_en && wr_addr < NPIX_A) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Single read port: address 0 is fetched on the last CRST cycle, then pix.
  always_comb begin
    rd_addr = '0;
    if (state == S_STREAM) rd_addr = pix;
  end

  assign is_hit = (decision_in == lbl);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      cnn_rst_n       <= 1'b0;
      data_out        <= 8'd0;
      result_valid    <= 1'b0;
      result_decision <= 4'd0;
      result_hit      <= 1'b0;
      result_timeout  <= 1'b0;
      img_count       <= '0;
      hit_count       <= '0;
      rst_cnt         <= 4'd0;
      pix             <= '0;
      wcnt            <= '0;
      lbl             <= 4'd0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cnn_rst_n <= 1'b1;
          if (start) begin
            lbl       <= label;
            rst_cnt   <= 4'd0;
            cnn_rst_n <= 1'b0;
            busy      <= 1'b1;
            state     <= S_CRST;
          end
        end
        S_CRST: begin
          if (rst_cnt == RST_LAST) begin
            cnn_rst_n <= 1'b1;
            data_out  <= mem[rd_addr];
            pix       <= PW'(1);
            state     <= S_STREAM;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        S_STREAM: begin
          if (pix == PIX_END) begin
            data_out <= 8'd0;
            wcnt     <= '0;
            state    <= S_WAIT;
          end else begin
            data_out <= mem[rd_addr];
            pix      <= pix + PW'(1);
          end
        end
        S_WAIT: begin
          // A valid decision in the final timeout cycle still takes priority.
          if (valid_in) begin
            result_decision <= decision_in;
            result_hit      <= is_hit;
            result_timeout  <= 1'b0;
            result_valid    <= 1'b1;
            if (img_count != CNT_MAX) img_count <= img_count + 1'b1;
            if (is_hit && hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
            state <= S_DONE;
          end else if (wcnt == TO_LAST) begin
            result_decision <= 4'hF;
            result_hit      <= 1'b0;
            result_timeout  <= 1'b1;
            result_valid    <= 1'b1;
            if (img_count != CNT_MAX) img_count <= img_count + 1'b1;
            state <= S_DONE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_pixel_feeder.sv
// Self-checking bench for cnn_pixel_feeder: frame model, pixel and result
// scoreboards, latency checks on reset pulse, stream, result and timeout.
module tb_cnn_pixel_feeder;

  localparam int NPIX    = 784;
  localparam int TIMEOUT = 4096;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [9:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             start;
  logic [3:0]       label;
  logic             busy;
  logic             cnn_rst_n;
  logic [7:0]       data_out;
  logic             valid_in;
  logic [3:0]       decision_in;
  logic             result_valid;
  logic [3:0]       result_decision;
  logic             result_hit;
  logic             result_timeout;
  logic [CNT_W-1:0] img_count;
  logic [CNT_W-1:0] hit_count;

  cnn_pixel_feeder #(
    .NPIX(NPIX), .RST_CYCLES(1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .label(label), .busy(busy),
    .cnn_rst_n(cnn_rst_n), .data_out(data_out), .valid_in(valid_in),
    .decision_in(decision_in), .result_valid(result_valid),
    .result_decision(result_decision), .result_hit(result_hit),
    .result_timeout(result_timeout), .img_count(img_count),
    .hit_count(hit_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [7:0] model_mem [NPIX];
  logic [7:0] exp_q[$];
  logic [5:0] res_q[$];
  logic [3:0] lbl_model;
  int         img_exp;
  int         hit_exp;
  int         checks;
  int         errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // drivers
  task automatic write_pix(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 10'(a); wr_data = d;
    if (a < NPIX) model_mem[a] = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(model_mem[i]);
  endtask

  task automatic do_start(input logic [3:0] lbl, input bit with_wr,
                          input int a, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; label = lbl;
    if (with_wr) begin
      wr_en = 1'b1; wr_addr = 10'(a); wr_data = d;
      if (a < NPIX) model_mem[a] = d;
    end
    lbl_model = lbl;
    push_frame();
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Stream from CRST; returns at the WAIT-entry negedge, or right after
  // asserting rst_n=0 at pixel abort_at.
  task automatic stream_frame(input int abort_at, input bit poke);
    logic [7:0] e;
    @(negedge clk);
    check("crst_low", cnn_rst_n, 0);
    check("crst_busy", busy, 1);
    for (int k = 0; k < NPIX; k++) begin
      @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check($sformatf("pix%0d", k), data_out, e);
      check("stream_rst_n", cnn_rst_n, 1);
      check("stream_busy", busy, 1);
      check("stream_no_result", result_valid, 0);
      wr_en = 1'b0; start = 1'b0; valid_in = 1'b0;
      if (poke) begin
        if (k == 100) begin wr_en = 1'b1; wr_addr = 10'd0; wr_data = 8'hAA; end
        if (k == 200) begin start = 1'b1; label = 4'd9; end
        if (k == 300) begin valid_in = 1'b1; decision_in = 4'd2; end
      end
      if (k == abort_at) begin
        rst_n = 1'b0;
        return;
      end
    end
    @(negedge clk);
    check("wait_data0", data_out, 0);
    check("wait_busy", busy, 1);
  endtask

  task automatic push_result(input logic [3:0] dec, input bit hit, input bit to);
    res_q.push_back({dec, hit, to});
    img_exp++;
    if (hit) hit_exp++;
  endtask

  task automatic wait_result(input int max_cyc, output int lat);
    logic [5:0] e;
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (result_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      check("result_timeout_bound", 0, 1);
      return;
    end
    e = (res_q.size() > 0) ? res_q.pop_front() : 6'hxx;
    check("res_decision", result_decision, e[5:2]);
    check("res_hit", result_hit, e[1]);
    check("res_timeout", result_timeout, e[0]);
    check("res_busy_done", busy, 1);
    check("img_count", img_count, img_exp);
    check("hit_count", hit_count, hit_exp);
    @(negedge clk);
    check("res_pulse_end", result_valid, 0);
    check("idle_busy", busy, 0);
    check("res_hold", result_decision, e[5:2]);
  endtask

  task automatic drive_valid(input logic [3:0] dec);
    repeat ($urandom_range(0, 20)) @(negedge clk);
    valid_in = 1'b1; decision_in = dec;
    push_result(dec, dec == lbl_model, 1'b0);
  endtask

  int lat;

  initial begin
    checks = 0; errors = 0; img_exp = 0; hit_exp = 0; lbl_model = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; label = '0; valid_in = 1'b0; decision_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cnn_rst_n", cnn_rst_n, 0);
    check("rst_data", data_out, 0);
    check("rst_rv", result_valid, 0);
    check("rst_dec", result_decision, 0);
    check("rst_hit", result_hit, 0);
    check("rst_to", result_timeout, 0);
    check("rst_img", img_count, 0);
    check("rst_hitc", hit_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cnn_rst_n", cnn_rst_n, 1);

    // ramp frame, correct decision
    for (int k = 0; k < NPIX; k++) write_pix(k, 8'(k % 256));
    do_start(4'd7, 1'b0, 0, 8'd0);
    stream_frame(-1, 1'b0);
    drive_valid(4'd7);
    wait_result(100, lat);
    check("valid_latency", lat, 1);

    // out-of-range write ignored, write+start in the same cycle, miss
    write_pix(800, 8'h11);
    write_pix(1023, 8'h22);
    for (int i = 0; i < 8; i++) write_pix($urandom_range(1, NPIX - 1), 8'($urandom_range(0, 255)));
    do_start(4'd3, 1'b1, 5, 8'h5A);
    stream_frame(-1, 1'b0);
    drive_valid(4'd5);
    wait_result(100, lat);
    check("valid_latency2", lat, 1);

    // timeout
    do_start(4'd4, 1'b0, 0, 8'd0);
    stream_frame(-1, 1'b0);
    push_result(4'hF, 1'b0, 1'b1);
    wait_result(TIMEOUT + 100, lat);
    check("timeout_latency", lat, TIMEOUT);

    // writes, start and valid during STREAM are ignored
    do_start(4'd2, 1'b0, 0, 8'd0);
    stream_frame(-1, 1'b1);
    drive_valid(4'd2);
    wait_result(100, lat);
    check("valid_latency3", lat, 1);

    // reset mid-stream at pixel 400
    do_start(4'd1, 1'b0, 0, 8'd0);
    stream_frame(400, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    img_exp = 0; hit_exp = 0;
    check("abort_busy", busy, 0);
    check("abort_cnn_rst_n", cnn_rst_n, 0);
    check("abort_data", data_out, 0);
    check("abort_rv", result_valid, 0);
    check("abort_dec", result_decision, 0);
    check("abort_img", img_count, 0);
    check("abort_hitc", hit_count, 0);
    @(negedge clk);
    check("abort_cnn_rst_n_rel", cnn_rst_n, 1);
    check("abort_idle_busy", busy, 0);
    repeat (5) begin
      @(negedge clk);
      check("abort_no_result", result_valid, 0);
    end

    // fresh frame after abort; pixel 0 must still hold its pre-stream value
    do_start(4'd9, 1'b0, 0, 8'd0);
    stream_frame(-1, 1'b0);
    drive_valid(4'd9);
    wait_result(100, lat);
    check("valid_latency4", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
